seq_rec_minseok: RTL and testbench

SEQ_REC_MINSEOK -- requirements
Module: seq_rec_minseok

---
 rtl/seq_rec_minseok_if.sv | 8 +
 rtl/seq_rec_minseok.sv | 44 ++++
 tb/tb_seq_rec_minseok.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/seq_rec_minseok_if.sv
// Serial bit stream into the 1-0-1 recognizer and its detect flag back out.
interface seq_rec_minseok_if;
   logic X;
   logic Z;

   modport master (output X, input Z);
   modport slave  (input X, output Z);
endinterface

// File: rtl/seq_rec_minseok.sv
// Mealy recognizer for overlapping "101" on a serial bit stream.
// Z is combinational, so it flags a match while the final 1 is still on X.
module seq_rec_minseok (
   input logic CLK,
   input logic nRESET,
   seq_rec_minseok_if.slave bus
);

   typedef enum logic [1:0] {
      S0 = 2'b00,
      S1 = 2'b01,
      S2 = 2'b10
   } state_t;

   state_t state;
   state_t state_next;

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state <= S0;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = S0;
      bus.Z      = 1'b0;
      case (state)
         S0: state_next = bus.X ? S1 : S0;
         S1: state_next = bus.X ? S1 : S2;
         S2: begin
            // A completed match leaves its trailing 1 as the start of the next one
            state_next = bus.X ? S1 : S0;
            bus.Z      = bus.X;
         end
         default: begin
            state_next = S0;
            bus.Z      = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_rec_minseok.sv
// Directed self-checking bench for the 1-0-1 recognizer.
module tb_seq_rec_minseok;

   logic CLK;
   logic nRESET;
   int   nasserts;
   int   nfails;

   seq_rec_minseok_if bus ();

   seq_rec_minseok dut (
      .CLK    (CLK),
      .nRESET (nRESET),
      .bus    (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached, expected finish before 200000");
      $fatal(1, "timeout");
   end

   // X changes 1 time unit after the rising edge; Z is sampled at the falling edge.
   task automatic drive_bit(input logic b);
      @(posedge CLK);
      #1 bus.X = b;
      @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      bus.X  = 1'b0;
      nRESET = 1'b0;
      #2 nRESET = 1'b1;
   endtask

   task automatic test_reset();
      logic [0:5] xs;
      xs = 6'b101101;
      nRESET = 1'b0;
      bus.X  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive_bit(xs[i]);
         nasserts++;
         if (bus.Z !== 1'b0) begin
            nfails++;
            $display("FAIL reset_z step %0d: Z=%b expected 0", i, bus.Z);
         end
         nasserts++;
         if (dut.state !== 2'd0) begin
            nfails++;
            $display("FAIL reset_state step %0d: state=%0d expected 0", i, dut.state);
         end
      end
      @(negedge CLK);
      nRESET = 1'b1;
   endtask

   task automatic test_stream(input string name, input int n,
                              input logic [0:15] stim, input logic [0:15] expz);
      do_reset();
      for (int i = 0; i < n; i++) begin
         drive_bit(stim[i]);
         nasserts++;
         if (bus.Z !== expz[i]) begin
            nfails++;
            $display("FAIL %s bit %0d: Z=%b expected %b", name, i + 1, bus.Z, expz[i]);
         end
      end
   endtask

   task automatic test_mixed();
      test_stream("mixed", 13, 16'b1100110110101000, 16'b0000000100101000);
   endtask

   task automatic test_overlap();
      test_stream("overlap", 5, 16'b1010100000000000, 16'b0010100000000000);
      test_stream("overlap_1101", 4, 16'b1101000000000000, 16'b0001000000000000);
   endtask

   task automatic test_non_match();
      logic [0:6] xs;
      xs = 7'b1001000;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive_bit(xs[i]);
         nasserts++;
         if (bus.Z !== 1'b0) begin
            nfails++;
            $display("FAIL non_match bit %0d: Z=%b expected 0", i + 1, bus.Z);
         end
         // During bit 4 the state reflects bits 1..3 ("100")
         if (i == 3) begin
            nasserts++;
            if (dut.state !== 2'd0) begin
               nfails++;
               $display("FAIL non_match_state: state=%0d expected 0", dut.state);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      drive_bit(1'b1);
      drive_bit(1'b0);
      @(posedge CLK);
      #1 bus.X = 1'b0;
      nasserts++;
      if (dut.state !== 2'd2) begin
         nfails++;
         $display("FAIL mid_reset_pre: state=%0d expected 2", dut.state);
      end
      nRESET = 1'b0;
      #1;
      nasserts++;
      if (dut.state !== 2'd0) begin
         nfails++;
         $display("FAIL mid_reset_async: state=%0d expected 0", dut.state);
      end
      #1 nRESET = 1'b1;
      bus.X = 1'b1;
      @(negedge CLK);
      nasserts++;
      if (bus.Z !== 1'b0) begin
         nfails++;
         $display("FAIL mid_reset_first1: Z=%b expected 0", bus.Z);
      end
      drive_bit(1'b0);
      nasserts++;
      if (bus.Z !== 1'b0) begin
         nfails++;
         $display("FAIL mid_reset_0: Z=%b expected 0", bus.Z);
      end
      drive_bit(1'b1);
      nasserts++;
      if (bus.Z !== 1'b1) begin
         nfails++;
         $display("FAIL mid_reset_final1: Z=%b expected 1", bus.Z);
      end
   endtask

   task automatic test_comb_timing();
      do_reset();
      drive_bit(1'b1);
      drive_bit(1'b0);
      @(posedge CLK);
      #1 bus.X = 1'b0;
      #1;
      nasserts++;
      if (bus.Z !== 1'b0) begin
         nfails++;
         $display("FAIL comb_x0a: Z=%b expected 0", bus.Z);
      end
      bus.X = 1'b1;
      #1;
      nasserts++;
      if (bus.Z !== 1'b1) begin
         nfails++;
         $display("FAIL comb_x1: Z=%b expected 1", bus.Z);
      end
      bus.X = 1'b0;
      #1;
      nasserts++;
      if (bus.Z !== 1'b0) begin
         nfails++;
         $display("FAIL comb_x0b: Z=%b expected 0", bus.Z);
      end
   endtask

   initial begin
      nasserts = 0;
      nfails   = 0;
      nRESET   = 1'b0;
      bus.X    = 1'b0;
      test_reset();
      test_mixed();
      test_overlap();
      test_non_match();
      test_mid_reset();
      test_comb_timing();
      $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfails);
      $finish;
   end

endmodule
